// File: rtl/fetch_packet_rx_pkg.sv
// Shared sizing for the fetch-stage-2 packet receive path.
// Packet layout: {instruction, pc, targetAddr, ctiqTag, prediction}.
package fetch_packet_rx_pkg;

    localparam int unsigned SIZE_INSTRUCTION = 32;
    localparam int unsigned SIZE_PC          = 32;
    localparam int unsigned SIZE_CTI_LOG     = 4;
    localparam int unsigned FETCH_BANDWIDTH  = 4;
    localparam int unsigned FETCH_RX_DEPTH   = 8;
    localparam int unsigned SIZE_FETCH_PKT   =
        SIZE_INSTRUCTION + 2 * SIZE_PC + SIZE_CTI_LOG + 1;

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hffff_ffff : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_packet_rx_inst_lane_compact.sv
// Combinational lane compactor: packs the valid input lanes, in lane order,
// into the low output slots and reports how many were valid.
module fetch_packet_rx_inst_lane_compact
    import fetch_packet_rx_pkg::*;
#(
    parameter int unsigned WIDTH = FETCH_BANDWIDTH,
    parameter int unsigned PKT_W = SIZE_FETCH_PKT,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]            valid_i,
    input  logic [WIDTH-1:0][PKT_W-1:0] pkt_i,
    output logic [WIDTH-1:0][PKT_W-1:0] pkt_o,
    output logic [CNT_W-1:0]            n_in_o
);

    logic [CNT_W-1:0] slot;

    // Each valid lane lands in the slot equal to the number of valid lanes below it.
    always_comb begin
        slot  = '0;
        pkt_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (valid_i[i]) begin
                pkt_o[slot[CNT_W-2:0]] = pkt_i[i];
                slot = slot + CNT_W'(1);
            end
        end
        n_in_o = slot;
    end

endmodule

// File: rtl/fetch_packet_rx.sv
// Fetch-stage-2 packet receiver: compacts up to four packets per cycle into a
// circular buffer and delivers up to four per cycle, oldest first, to decode.
// Optional feature macro: FETCH_RX_PERF_EN (stall / delivered perf counters).
module fetch_packet_rx
    import fetch_packet_rx_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_RX_DEPTH,
    parameter int unsigned WIDTH = FETCH_BANDWIDTH,
    parameter int unsigned PKT_W = SIZE_FETCH_PKT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fs2Ready_i,
    input  logic                     inst0Valid_i,
    input  logic                     inst1Valid_i,
    input  logic                     inst2Valid_i,
    input  logic                     inst3Valid_i,
    input  logic [PKT_W-1:0]         inst0Packet_i,
    input  logic [PKT_W-1:0]         inst1Packet_i,
    input  logic [PKT_W-1:0]         inst2Packet_i,
    input  logic [PKT_W-1:0]         inst3Packet_i,
    input  logic                     flush_i,
    input  logic                     recoverFlag_i,
    input  logic                     decodeReady_i,
    output logic                     stall_o,
    output logic                     out0Valid_o,
    output logic                     out1Valid_o,
    output logic                     out2Valid_o,
    output logic                     out3Valid_o,
    output logic [PKT_W-1:0]         out0Packet_o,
    output logic [PKT_W-1:0]         out1Packet_o,
    output logic [PKT_W-1:0]         out2Packet_o,
    output logic [PKT_W-1:0]         out3Packet_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef FETCH_RX_PERF_EN
    ,
    output logic [31:0]              perfStallCycles_o,
    output logic [31:0]              perfInstDelivered_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NW    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] StallThresh = CNT_W'(DEPTH - WIDTH);
    localparam logic [CNT_W-1:0] WidthCnt    = CNT_W'(WIDTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PKT_W-1:0] mem_d [DEPTH];

    logic [WIDTH-1:0]            in_valid;
    logic [WIDTH-1:0][PKT_W-1:0] in_pkt;
    logic [WIDTH-1:0][PKT_W-1:0] comp_pkt;
    logic [NW-1:0]               n_in;
    logic [CNT_W-1:0]            n_out;
    logic                        kill, stall, enq, deq;
    logic [WIDTH-1:0]            out_valid;
    logic [WIDTH-1:0][PKT_W-1:0] out_pkt;

    assign in_valid = {inst3Valid_i, inst2Valid_i, inst1Valid_i, inst0Valid_i};
    assign in_pkt   = {inst3Packet_i, inst2Packet_i, inst1Packet_i, inst0Packet_i};

    fetch_packet_rx_inst_lane_compact #(
        .WIDTH (WIDTH),
        .PKT_W (PKT_W),
        .CNT_W (NW)
    ) u_compact (
        .valid_i (in_valid),
        .pkt_i   (in_pkt),
        .pkt_o   (comp_pkt),
        .n_in_o  (n_in)
    );

    // Handshake decode; stall looks only at registered count, ignoring a same-cycle dequeue.
    always_comb begin
        kill  = flush_i | recoverFlag_i;
        stall = count_q > StallThresh;
        enq   = fs2Ready_i & ~stall & ~kill;
        deq   = decodeReady_i & ~kill;
        n_out = (count_q > WidthCnt) ? WidthCnt : count_q;
    end

    // Pointer and occupancy next state; flush/recover overrides everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (kill) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(n_in);
            if (deq) head_d = head_q + PTR_W'(n_out);
            count_d = count_q + (enq ? CNT_W'(n_in) : '0) - (deq ? n_out : '0);
        end
    end

    // Compacted lanes are written at tail, tail+1, ... wrapping modulo DEPTH.
    always_comb begin
        mem_d = mem_q;
        if (enq) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (NW'(k) < n_in) mem_d[tail_q + PTR_W'(k)] = comp_pkt[k];
            end
        end
    end

    // Output lanes show head..head+n_out-1; unused lanes are zeroed.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            out_valid[k] = CNT_W'(k) < n_out;
            out_pkt[k]   = out_valid[k] ? mem_q[head_q + PTR_W'(k)] : '0;
        end
    end

    assign stall_o      = stall;
    assign count_o      = count_q;
    assign out0Valid_o  = out_valid[0];
    assign out1Valid_o  = out_valid[1];
    assign out2Valid_o  = out_valid[2];
    assign out3Valid_o  = out_valid[3];
    assign out0Packet_o = out_pkt[0];
    assign out1Packet_o = out_pkt[1];
    assign out2Packet_o = out_pkt[2];
    assign out3Packet_o = out_pkt[3];

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef FETCH_RX_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_deliv_q, perf_deliv_d;

    // Saturating perf counters; flush does not clear them.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_deliv_d = perf_deliv_q;
        if (stall & fs2Ready_i) perf_stall_d = sat_add32(perf_stall_q, 32'd1);
        if (deq) perf_deliv_d = sat_add32(perf_deliv_q, 32'(n_out));
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_deliv_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_deliv_q <= perf_deliv_d;
        end
    end

    assign perfStallCycles_o   = perf_stall_q;
    assign perfInstDelivered_o = perf_deliv_q;
`endif

endmodule

// File: tb/tb_fetch_packet_rx.sv
// Directed self-checking bench for fetch_packet_rx.
module tb_fetch_packet_rx;
    import fetch_packet_rx_pkg::*;

    localparam int unsigned PKT_W = SIZE_FETCH_PKT;

    logic             clk = 1'b0;
    logic             reset;
    logic             fs2_ready, flush, recover, dec_ready;
    logic [3:0]       v;
    logic [PKT_W-1:0] p [4];
    logic             stall;
    logic [3:0]       ov;
    logic [PKT_W-1:0] op [4];
    logic [3:0]       count;
    int               n_cmp = 0;
    int               n_err = 0;
`ifdef FETCH_RX_PERF_EN
    logic [31:0]      perf_stall, perf_deliv, deliv_before;
`endif

    always #5 clk = ~clk;

    fetch_packet_rx dut (
        .clk           (clk),
        .reset         (reset),
        .fs2Ready_i    (fs2_ready),
        .inst0Valid_i  (v[0]),
        .inst1Valid_i  (v[1]),
        .inst2Valid_i  (v[2]),
        .inst3Valid_i  (v[3]),
        .inst0Packet_i (p[0]),
        .inst1Packet_i (p[1]),
        .inst2Packet_i (p[2]),
        .inst3Packet_i (p[3]),
        .flush_i       (flush),
        .recoverFlag_i (recover),
        .decodeReady_i (dec_ready),
        .stall_o       (stall),
        .out0Valid_o   (ov[0]),
        .out1Valid_o   (ov[1]),
        .out2Valid_o   (ov[2]),
        .out3Valid_o   (ov[3]),
        .out0Packet_o  (op[0]),
        .out1Packet_o  (op[1]),
        .out2Packet_o  (op[2]),
        .out3Packet_o  (op[3]),
        .count_o       (count)
`ifdef FETCH_RX_PERF_EN
        ,
        .perfStallCycles_o   (perf_stall),
        .perfInstDelivered_o (perf_deliv)
`endif
    );

    // Packet derived from its pc so every field is distinguishable.
    function automatic logic [PKT_W-1:0] mk(input logic [31:0] pc);
        return {~pc, pc, pc + 32'h40, pc[5:2], pc[3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane i carries pc0 + 8*i whether or not it is valid.
    task automatic bundle(input logic [3:0] vv, input logic [31:0] pc0);
        v = vv;
        for (int i = 0; i < 4; i++) p[i] = mk(pc0 + 32'(8 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; fs2_ready = 1'b0; flush = 1'b0; recover = 1'b0; dec_ready = 1'b0;
        bundle(4'b0000, 32'h0);

        // Reset
        tick(); tick();
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_stall", 128'(stall), 128'd0);
        chk("rst_valids", 128'(ov), 128'd0);
        chk("rst_pkt0", 128'(op[0]), 128'd0);
        chk("rst_pkt3", 128'(op[3]), 128'd0);
`ifdef FETCH_RX_PERF_EN
        chk("rst_perf_stall", 128'(perf_stall), 128'd0);
        chk("rst_perf_deliv", 128'(perf_deliv), 128'd0);
`endif
        reset = 1'b1;

        // Single bundle, lanes 0 and 1
        bundle(4'b0011, 32'h100); fs2_ready = 1'b1;
        tick(); fs2_ready = 1'b0;
        chk("single_count", 128'(count), 128'd2);
        chk("single_valids", 128'(ov), 128'b0011);
        chk("single_out0", 128'(op[0]), 128'(mk(32'h100)));
        chk("single_out1", 128'(op[1]), 128'(mk(32'h108)));
        chk("single_out2_zero", 128'(op[2]), 128'd0);

        // Recovery clears
        recover = 1'b1;
        tick(); recover = 1'b0;
        chk("recover_count", 128'(count), 128'd0);
        chk("recover_valids", 128'(ov), 128'd0);

        // Sparse compaction and wrap
        bundle(4'b1111, 32'h200); fs2_ready = 1'b1;
        tick();
        chk("pre_count4", 128'(count), 128'd4);
        chk("pre_stall4", 128'(stall), 128'd0);
        bundle(4'b0011, 32'h220);
        tick(); fs2_ready = 1'b0;
        chk("pre_count6", 128'(count), 128'd6);
        chk("pre_stall6", 128'(stall), 128'd1);
        dec_ready = 1'b1;
        tick(); dec_ready = 1'b0;
        chk("deq_count2", 128'(count), 128'd2);
        chk("deq_valids", 128'(ov), 128'b0011);
        chk("deq_out0", 128'(op[0]), 128'(mk(32'h220)));
        chk("deq_out1", 128'(op[1]), 128'(mk(32'h228)));
        bundle(4'b0101, 32'h300); fs2_ready = 1'b1;
        tick();
        chk("sparse_count", 128'(count), 128'd4);
        chk("sparse_out2_A", 128'(op[2]), 128'(mk(32'h300)));
        chk("sparse_out3_C", 128'(op[3]), 128'(mk(32'h310)));
        bundle(4'b1111, 32'h320);
        tick(); fs2_ready = 1'b0;
        chk("wrap_count8", 128'(count), 128'd8);
        chk("wrap_stall", 128'(stall), 128'd1);
        dec_ready = 1'b1;
        tick();
        chk("wrap_deq_count", 128'(count), 128'd4);
        chk("wrap_out0", 128'(op[0]), 128'(mk(32'h320)));
        chk("wrap_out3", 128'(op[3]), 128'(mk(32'h338)));
        tick(); dec_ready = 1'b0;
        chk("empty_count", 128'(count), 128'd0);
        chk("empty_valids", 128'(ov), 128'd0);

        // Fill to full, third bundle held
        bundle(4'b1111, 32'h400); fs2_ready = 1'b1;
        tick();
        chk("fill1_count", 128'(count), 128'd4);
        chk("fill1_stall", 128'(stall), 128'd0);
        bundle(4'b1111, 32'h420);
        tick();
        chk("fill2_count", 128'(count), 128'd8);
        chk("fill2_stall", 128'(stall), 128'd1);
        bundle(4'b1111, 32'h440);
        tick();
        chk("full_hold_count", 128'(count), 128'd8);
        chk("full_hold_out0", 128'(op[0]), 128'(mk(32'h400)));
        dec_ready = 1'b1;
        tick(); dec_ready = 1'b0;
        chk("full_deq_count", 128'(count), 128'd4);
        chk("full_deq_stall", 128'(stall), 128'd0);
        chk("full_deq_out0", 128'(op[0]), 128'(mk(32'h420)));
        tick(); fs2_ready = 1'b0;
        chk("third_acc_count", 128'(count), 128'd8);
        dec_ready = 1'b1;
        tick(); dec_ready = 1'b0;
        chk("third_out0", 128'(op[0]), 128'(mk(32'h440)));
        chk("third_out3", 128'(op[3]), 128'(mk(32'h458)));

        // Flush with simultaneous enqueue/dequeue at count 5
        bundle(4'b0001, 32'h460); fs2_ready = 1'b1;
        tick();
        chk("five_count", 128'(count), 128'd5);
        chk("five_stall", 128'(stall), 128'd1);
        bundle(4'b1111, 32'h480); flush = 1'b1; dec_ready = 1'b1;
        tick(); flush = 1'b0; dec_ready = 1'b0; fs2_ready = 1'b0;
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_stall", 128'(stall), 128'd0);
        chk("flush_valids", 128'(ov), 128'd0);
        tick();
        chk("flush_nothing_enq", 128'(count), 128'd0);

        // Simultaneous enqueue and dequeue
        bundle(4'b1111, 32'h500); fs2_ready = 1'b1;
        tick();
`ifdef FETCH_RX_PERF_EN
        deliv_before = perf_deliv;
`endif
        bundle(4'b0111, 32'h520); dec_ready = 1'b1;
        tick(); fs2_ready = 1'b0; dec_ready = 1'b0;
        chk("sim_count", 128'(count), 128'd3);
        chk("sim_valids", 128'(ov), 128'b0111);
        chk("sim_out0", 128'(op[0]), 128'(mk(32'h520)));
        chk("sim_out2", 128'(op[2]), 128'(mk(32'h530)));
`ifdef FETCH_RX_PERF_EN
        chk("sim_perf_deliv", 128'(perf_deliv - deliv_before), 128'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_packet_rx.md
# fetch_packet_rx

Receiving end of the FetchStage2 instruction-packet interface. Accepts up to four predecoded instruction packets per cycle with per-lane valids and compacts them in program order into an 8-entry circular buffer. Delivers up to four packets per cycle, oldest first, to decode. Back-pressures fetch through `stall_o`, and discards all contents on flush or recovery.

## Interface

Parameters:
- `DEPTH`, 8: buffer entries; power of two, at least 2×`WIDTH`.
- `WIDTH`, 4: lanes per cycle; equals `` `FETCH_BANDWIDTH ``.
- `PKT_W`, `` `SIZE_INSTRUCTION+2*`SIZE_PC+`SIZE_CTI_LOG+1 ``: packet width.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `fs2Ready_i` in 1: fetch-stage-2 bundle is valid this cycle.
- `inst0Valid_i`..`inst3Valid_i` in 1 each: lane valids; lane 0 is oldest.
- `inst0Packet_i`..`inst3Packet_i` in `PKT_W` each: `{instruction, pc, targetAddr, ctiqTag, prediction}`.
- `flush_i` in 1: pipeline flush.
- `recoverFlag_i` in 1: branch recovery; treated identically to flush.
- `decodeReady_i` in 1: decode accepts this cycle's output lanes.
- `stall_o` out 1: fetch must hold; bundle not accepted.
- `out0Valid_o`..`out3Valid_o` out 1 each: output lane valids, always a contiguous prefix from lane 0.
- `out0Packet_o`..`out3Packet_o` out `PKT_W` each: output packets, oldest in lane 0.
- `count_o` out 4: current occupancy, 0..8.

## Operation

- **State:** `head` and `tail` pointers of log2(`DEPTH`) bits, wrapping modulo `DEPTH`; `count` of log2(`DEPTH`)+1 bits; entry storage.
- **Stall:** `stall_o = (DEPTH - count) < WIDTH`.
  - Computed from registered `count` only.
  - Conservative: ignores a dequeue in the same cycle.
- **Enqueue:** when `enq = fs2Ready_i & ~stall_o & ~flush_i & ~recoverFlag_i`.
  - `n_in` = popcount of the four input valids.
  - Valid lanes are compacted in lane order into `tail`, `tail+1`, …, wrapping.
  - `tail += n_in`.
  - Any valid pattern is legal; invalid lanes write nothing.
- **Output:** `n_out = min(count, 4)`.
  - Output lane k carries the entry at `head+k`.
  - `outkValid_o = (k < n_out)`.
  - Invalid lanes drive `PKT_W'b0`.
- **Dequeue:** when `decodeReady_i & ~flush_i & ~recoverFlag_i`, then `head += n_out`. Dequeue is all-or-nothing; there is no partial accept.
- **Count update:** `count_next = count + n_in·enq − n_out·deq`. Simultaneous enqueue and dequeue are legal.
- **Flush/recover:** highest priority.
  - Next cycle: `head = tail = count = 0`.
  - The same-cycle bundle is dropped and the same-cycle output is not consumed.
- **Reset (`reset`=0 at edge):** `head = tail = count = 0`. Entry storage is not reset.
- **Reset values:** `stall_o = 0`, all `outkValid_o = 0`, all `outkPacket_o = 0`, `count_o = 0`.

## Timing

- Latency: a packet accepted at edge N is visible on the outputs in cycle N+1. There is no input-to-output bypass.
- All outputs are functions of registered state only; there is no combinational path from any input to any output.
- Full (`count` = 8): `stall_o = 1` and enqueue is blocked. Dequeue of up to 4 still proceeds.
- `count` ≥ 5: `stall_o = 1`.
- Empty: all output valids are 0 and a dequeue is a no-op.
- Pointer wrap from 7 to 0 occurs mid-bundle without a gap.
- Flush while `stall_o = 1`: `stall_o` drops in the following cycle.

## Configuration

- `FETCH_RX_PERF_EN` defined adds two outputs and two counters:
  - `perfStallCycles_o` (32): increments every cycle with `stall_o & fs2Ready_i`.
  - `perfInstDelivered_o` (32): adds `n_out` on each dequeue.
  - Both counters clear on reset, saturate at all-ones, and are not cleared by flush.
- `FETCH_RX_PERF_EN` undefined: these ports and counters are absent and behaviour is otherwise identical.

## Structure

- Shared package/defines hold `` `SIZE_INSTRUCTION ``, `` `SIZE_PC ``, `` `SIZE_CTI_LOG ``, `` `FETCH_BANDWIDTH ``, plus a new `` `FETCH_RX_DEPTH `` and `` `SIZE_FETCH_PKT ``.
- Sub-module `InstLaneCompact`: combinational.
  - Inputs: 4 valids and 4 packets.
  - Outputs: compacted packets and `n_in`.
- Pointer, count, storage and flush logic stay in the top module.

## Test plan

- **Reset:** hold `reset`=0 for 2 cycles → `count_o=0`, `stall_o=0`, all out valids 0.
- **Single bundle:** valids 1100, PCs 0x100/0x108, `decodeReady_i=0` → next cycle `count_o=2`; out0 pc=0x100, out1 pc=0x108; `out0Valid_o`/`out1Valid_o`=1, out2/out3 valids 0.
- **Sparse compaction and wrap:** preload 6, dequeue 4, then enqueue valids 1010 (pc A at lane 0, C at lane 2) and 1111 → entries land at indices 6, 7, 0 … in order A, C, then the 4 new packets; `count_o` tracks exactly.
- **Fill to full:** three 1111 bundles with decode stalled → first two accepted, `count_o=8`, `stall_o=1`, third held. Assert `decodeReady_i` → 4 delivered, `count_o=4`, `stall_o=0`, third accepted next edge.
- **Flush with simultaneous events:** `count`=5, `flush_i=1` with a 1111 input and `decodeReady_i=1` → next cycle `count_o=0`, no valids out, nothing enqueued.
- **Simultaneous enq/deq at steady state:** `count`=4, enqueue 1110 with `decodeReady_i=1` → `count_o=3`, order preserved. With `FETCH_RX_PERF_EN`, `perfInstDelivered_o` increases by 4.
